// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared types and helpers for the sync_fifo_flagged block.
//   fifo_mode_e : read-side mode (registered read or first-word-fall-through)
//   fifo_depth  : number of words for a given address width
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int unsigned fifo_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/sync_fifo_dpram.sv
// sync_fifo_dpram
//   Simple dual-port word memory: one synchronous write port, one asynchronous read port.
//   Contents are not reset.
// Ports
//   clk    in  clock (write on posedge)
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data, combinational from raddr
module sync_fifo_dpram #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged
//   Single-clock FIFO with fill level, almost-full/almost-empty watermarks, sticky
//   overflow/underflow errors and synchronous flush. Read side is either first-word-
//   fall-through (FWFT=1) or registered with one cycle of latency (FWFT=0).
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   flush                  synchronous clear of pointers, level, flags and errors
//   wen, wdata             write request and data
//   wfull, walmost_full    level == DEPTH, level >= AFULL_LEVEL
//   overflow               sticky: write attempted while full
//   ren                    read (pop) request
//   rdata, rvalid          read data and its valid
//   rempty, ralmost_empty  level == 0, level <= AEMPTY_LEVEL
//   underflow              sticky: read attempted while empty
//   level                  words stored, 0..DEPTH
module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter bit          FWFT         = 1'b1,
    parameter int unsigned AFULL_LEVEL  = 6,
    parameter int unsigned AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic                  overflow,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
    localparam fifo_mode_e  MODE  = fifo_mode_e'(FWFT);

    localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH + 1)'(1);

    // Elaboration-time range checks on the watermark parameters.
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : gen_afull_range_err
        $error("sync_fifo_flagged: AFULL_LEVEL out of range 1..DEPTH");
    end
    if (AEMPTY_LEVEL > DEPTH - 1) begin : gen_aempty_range_err
        $error("sync_fifo_flagged: AEMPTY_LEVEL out of range 0..DEPTH-1");
    end

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] level_q, level_d;
    logic                wfull_q, wfull_d;
    logic                walmost_full_q, walmost_full_d;
    logic                rempty_q, rempty_d;
    logic                ralmost_empty_q, ralmost_empty_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                  wincr;
    logic                  rincr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Acceptance uses only this cycle's registered flags; flush blocks both sides.
    assign wincr = wen & ~wfull_q  & ~flush;
    assign rincr = ren & ~rempty_q & ~flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wincr) begin
                wptr_d = wptr_q + ONE;
            end
            if (rincr) begin
                rptr_d = rptr_q + ONE;
            end
            if (wincr && !rincr) begin
                level_d = level_q + ONE;
            end else if (rincr && !wincr) begin
                level_d = level_q - ONE;
            end
            if (wen && wfull_q) begin
                overflow_d = 1'b1;
            end
            if (ren && rempty_q) begin
                underflow_d = 1'b1;
            end
        end

        // Flags are registered copies of the next level so they never lag the count.
        wfull_d         = (level_d == DEPTH_LVL);
        walmost_full_d  = (level_d >= AFULL_LVL);
        rempty_d        = (level_d == '0);
        ralmost_empty_d = (level_d <= AEMPTY_LVL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            level_q         <= '0;
            wfull_q         <= 1'b0;
            walmost_full_q  <= 1'b0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            level_q         <= level_d;
            wfull_q         <= wfull_d;
            walmost_full_q  <= walmost_full_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    sync_fifo_dpram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wincr),
        .waddr (wptr_q[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    if (MODE == FIFO_FWFT) begin : gen_fwft
        assign rdata  = mem_rdata;
        assign rvalid = ~rempty_q;
    end else begin : gen_reg
        logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
        logic                  rvalid_q, rvalid_d;

        always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = rincr;
            if (rincr) begin
                rdata_d = mem_rdata;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

    assign level         = level_q;
    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// tb_sync_fifo_flagged
//   Drives one FWFT instance and one registered-read instance with identical stimulus.
//   A queue-based model predicts every output; literal checks pin the model at key points.
module tb_sync_fifo_flagged;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wen = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       ren = 1'b0;

    logic       f_wfull, f_walmost_full, f_overflow, f_rvalid, f_rempty;
    logic       f_ralmost_empty, f_underflow;
    logic [7:0] f_rdata;
    logic [3:0] f_level;
    logic       r_wfull, r_walmost_full, r_overflow, r_rvalid, r_rempty;
    logic       r_ralmost_empty, r_underflow;
    logic [7:0] r_rdata;
    logic [3:0] r_level;

    int checks = 0;
    int failures = 0;
    bit running = 1'b0;

    // Model state
    logic [7:0] q[$];
    bit         m_over = 1'b0;
    bit         m_under = 1'b0;
    bit         m_rvalid = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_flagged #(
        .ADDR_WIDTH (3), .DATA_WIDTH (8), .FWFT (1'b1), .AFULL_LEVEL (6), .AEMPTY_LEVEL (2)
    ) u_fwft (
        .clk (clk), .reset (reset), .flush (flush), .wen (wen), .wdata (wdata),
        .wfull (f_wfull), .walmost_full (f_walmost_full), .overflow (f_overflow),
        .ren (ren), .rdata (f_rdata), .rvalid (f_rvalid), .rempty (f_rempty),
        .ralmost_empty (f_ralmost_empty), .underflow (f_underflow), .level (f_level)
    );

    sync_fifo_flagged #(
        .ADDR_WIDTH (3), .DATA_WIDTH (8), .FWFT (1'b0), .AFULL_LEVEL (6), .AEMPTY_LEVEL (2)
    ) u_reg (
        .clk (clk), .reset (reset), .flush (flush), .wen (wen), .wdata (wdata),
        .wfull (r_wfull), .walmost_full (r_walmost_full), .overflow (r_overflow),
        .ren (ren), .rdata (r_rdata), .rvalid (r_rvalid), .rempty (r_rempty),
        .ralmost_empty (r_ralmost_empty), .underflow (r_underflow), .level (r_level)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Apply one cycle of stimulus, advance the model across the edge, return idle.
    task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit f);
        int  n;
        bit  full, empty;
        logic [7:0] popped;
        wen = w; wdata = wd; ren = r; flush = f;
        @(posedge clk);
        n = q.size();
        full = (n == 8);
        empty = (n == 0);
        if (f) begin
            q.delete();
            m_over = 1'b0;
            m_under = 1'b0;
            m_rvalid = 1'b0;
        end else begin
            if (w && full) m_over = 1'b1;
            if (r && empty) m_under = 1'b1;
            m_rvalid = r && !empty;
            if (r && !empty) begin
                popped = q.pop_front();
                m_rdata = popped;
            end
            if (w && !full) q.push_back(wd);
        end
        #1;
        wen = 1'b0; ren = 1'b0; flush = 1'b0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (running && !reset) begin
            int n;
            n = q.size();
            chk("f_level", 32'(f_level), 32'(n));
            chk("r_level", 32'(r_level), 32'(n));
            chk("f_wfull", 32'(f_wfull), 32'(n == 8));
            chk("r_wfull", 32'(r_wfull), 32'(n == 8));
            chk("f_walmost_full", 32'(f_walmost_full), 32'(n >= 6));
            chk("r_walmost_full", 32'(r_walmost_full), 32'(n >= 6));
            chk("f_rempty", 32'(f_rempty), 32'(n == 0));
            chk("r_rempty", 32'(r_rempty), 32'(n == 0));
            chk("f_ralmost_empty", 32'(f_ralmost_empty), 32'(n <= 2));
            chk("r_ralmost_empty", 32'(r_ralmost_empty), 32'(n <= 2));
            chk("f_overflow", 32'(f_overflow), 32'(m_over));
            chk("r_overflow", 32'(r_overflow), 32'(m_over));
            chk("f_underflow", 32'(f_underflow), 32'(m_under));
            chk("r_underflow", 32'(r_underflow), 32'(m_under));
            chk("f_rvalid", 32'(f_rvalid), 32'(n != 0));
            if (n != 0) chk("f_rdata", 32'(f_rdata), 32'(q[0]));
            chk("r_rvalid", 32'(r_rvalid), 32'(m_rvalid));
            chk("r_rdata", 32'(r_rdata), 32'(m_rdata));
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_level", 32'(f_level), 32'd0);
        chk("rst_rempty", 32'(f_rempty), 32'd1);
        chk("rst_ralmost_empty", 32'(r_ralmost_empty), 32'd1);
        chk("rst_wfull", 32'(r_wfull), 32'd0);
        chk("rst_walmost_full", 32'(f_walmost_full), 32'd0);
        chk("rst_errors", 32'({f_overflow, f_underflow, r_overflow, r_underflow}), 32'd0);
        chk("rst_rvalid", 32'({f_rvalid, r_rvalid}), 32'd0);
        chk("rst_rdata_reg", 32'(r_rdata), 32'd0);
        reset = 1'b0;
        running = 1'b1;
        @(posedge clk); #1;

        // Fill 0x10..0x17, then one write too many
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            chk("fill_level", 32'(f_level), 32'(i + 1));
            chk("fill_afull", 32'(f_walmost_full), 32'(i >= 5));
            chk("fill_full", 32'(r_wfull), 32'(i == 7));
        end
        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("ovf_flag", 32'(f_overflow), 32'd1);
        chk("ovf_level", 32'(r_level), 32'd8);

        // Drain in order, then one read too many
        for (int i = 0; i < 8; i++) begin
            chk("drain_fwft_data", 32'(f_rdata), 32'(8'h10 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_reg_valid", 32'(r_rvalid), 32'd1);
            chk("drain_reg_data", 32'(r_rdata), 32'(8'h10 + i));
            chk("drain_aempty", 32'(f_ralmost_empty), 32'(i >= 5));
            chk("drain_empty", 32'(r_rempty), 32'(i == 7));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_flag", 32'(f_underflow), 32'd1);
        chk("udf_level", 32'(f_level), 32'd0);
        chk("udf_reg_valid", 32'(r_rvalid), 32'd0);

        // Steady streaming at level 4 across pointer wrap
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("stream_fwft_data", 32'(f_rdata), 32'(8'h20 + i));
            step(1'b1, 8'(8'h24 + i), 1'b1, 1'b0);
            chk("stream_level", 32'(r_level), 32'd4);
            chk("stream_reg_data", 32'(r_rdata), 32'(8'h20 + i));
        end

        // Write and read together on an empty FIFO
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("wr_empty_udf", 32'(r_underflow), 32'd1);
        chk("wr_empty_level", 32'(f_level), 32'd1);
        chk("wr_empty_reg_valid", 32'(r_rvalid), 32'd0);
        chk("wr_empty_fwft_data", 32'(f_rdata), 32'hAA);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wr_empty_pop", 32'(r_rdata), 32'hAA);

        // Registered read latency
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("reg_pre_valid", 32'(r_rvalid), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("reg_lat_valid", 32'(r_rvalid), 32'd1);
        chk("reg_lat_data", 32'(r_rdata), 32'h5A);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("reg_pulse_end", 32'(r_rvalid), 32'd0);
        chk("reg_hold_data", 32'(r_rdata), 32'h5A);

        // Flush at level 5 with both errors set and a write pending
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_flush_level", 32'(f_level), 32'd5);
        chk("pre_flush_errs", 32'({f_overflow, f_underflow}), 32'h3);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("flush_level", 32'(f_level), 32'd0);
        chk("flush_rempty", 32'(r_rempty), 32'd1);
        chk("flush_flags", 32'({f_wfull, f_walmost_full, f_ralmost_empty}), 32'h1);
        chk("flush_errs", 32'({r_overflow, r_underflow}), 32'h0);

        // Asynchronous reset right after an accepted pop
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("burst_valid", 32'(r_rvalid), 32'd1);
        #1;
        reset = 1'b1;
        q.delete(); m_over = 1'b0; m_under = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
        #1;
        chk("async_rst_valid", 32'(r_rvalid), 32'd0);
        chk("async_rst_level", 32'(f_level), 32'd0);
        chk("async_rst_rdata", 32'(r_rdata), 32'd0);
        #6;
        reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
